rob_operand_source: RTL and testbench
=====================================

// Module: rob_operand_source
// PURPOSE
// - Reorder buffer (ROB) that feeds the forwarding reservation-station pair and is fed back by it.
// - Producer side: allocates destination tags and returns 65-bit source operands to decode.
// - Result side: absorbs exec/mem results.
// - Retires in program order and broadcasts the committed tag and value to all reservation stations.
// PARAMETERS
// - ROBsize     8                        number of entries; tags run 1..ROBsize, tag 0 = "no producer / register file"
// - ROBsizeLog  $clog2(ROBsize+1)        tag width
// - RegIdxW     5                        architectural destination register index width
// PORTS
// - clk_i               in   1            single clock, rising edge
// - reset_i             in   1            asynchronous, active-high reset
// - decodeAlloc_i       in   1            request to allocate one entry this cycle
// - decodeDestReg_i     in   RegIdxW      destination register of the allocating instruction
// - decodeROBTag_o      out  ROBsizeLog   tag granted (tail); valid whenever full_o==0
// - full_o              out  1            all entries busy; decode must stall
// - empty_o             out  1            no busy entries
// - decodeSrcTag1_i     in   ROBsizeLog   producer tag of source 1 (0 = none)
// - decodeSrcTag2_i     in   ROBsizeLog   producer tag of source 2 (0 = none)
// - decodeRegVal1_i     in   64           register-file value for source 1
// - decodeRegVal2_i     in   64           register-file value for source 2
// - decodeROBval1_o     out  65           {ready,data} for source 1
// - decodeROBval2_o     out  65           {ready,data} for source 2
// - execValid_i         in   1            exec result valid
// - execTag_i           in   ROBsizeLog   exec result tag
// - execVal_i           in   64           exec result data
// - memValid_i          in   1            mem result valid
// - memTag_i            in   ROBsizeLog   mem result tag
// - memVal_i            in   64           mem result data
// - commitStall_i       in   1            hold retirement this cycle
// - flush_i             in   1            synchronous squash of all entries
// - issueROBTagCom_o    out  ROBsizeLog   committed tag (0 when none)
// - issueROBvalCom_o    out  65           {commitValid,data} broadcast to reservation stations
// - commitDestReg_o     out  RegIdxW      destination register of committed entry
// BEHAVIOUR
// - Reset (async):
//   - head=tail=1; count=0; all busy/done bits cleared.
//   - issueROBTagCom_o=0, issueROBvalCom_o=0, commitDestReg_o=0.
//   - full_o=0, empty_o=1, decodeROBTag_o=1.
// - Entry state: busy, done, destReg, data[63:0].
// - Alloc:
//   - At the edge where decodeAlloc_i & ~full_o: entry[tail] gets busy=1, done=0, destReg latched.
//   - tail advances; wraps ROBsize -> 1.
//   - Alloc while full is ignored; no state change.
// - Operand read (combinational), per source, first match wins:
//   1. tag==0 -> {1,regVal}.
//   2. entry busy&done -> {1,data}.
//   3. memValid_i & memTag_i==tag -> {1,memVal_i} (same-cycle bypass).
//   4. execValid_i & execTag_i==tag -> {1,execVal_i}.
//   5. else -> {0, 60'b0, tag}.
// - Writeback:
//   - At the edge where xValid_i and entry[xTag] is busy: done=1, data=xVal.
//   - Tag 0 or a non-busy tag is ignored.
//   - exec and mem hitting the same tag in one cycle: mem data wins.
// - Commit (registered outputs):
//   - At each edge, if ~commitStall_i & entry[head] busy&done:
//     - outputs <= {head tag, {1,data}, destReg}; entry cleared; head advances with wrap.
//   - Otherwise outputs <= 0 (tag 0, valid bit 0).
//   - Max one commit per cycle.
//   - Earliest commit output is one cycle after the writeback edge.
// - Count:
//   - +1 on alloc, -1 on commit; both in the same cycle leave it unchanged.
//   - full_o = (count==ROBsize); empty_o = (count==0); both combinational from registered count.
//   - When full, a same-cycle commit does not enable a same-cycle alloc.
// - Flush:
//   - Has priority over alloc, writeback and commit in that cycle.
//   - Clears all entries; head=tail=1, count=0; commit outputs <= 0.
// - Reset mid-operation: immediate async return to reset state; in-flight writebacks are lost.
// STRUCTURE
// - Package rob_pkg:
//   - constants ROB_VAL_W=65, ROB_READY_BIT=64, ROB_NULL_TAG=0.
//   - typedef rob_entry_t {busy, done, destReg, data}.
// - Sub-module rob_tag_ptr: wrapping 1..ROBsize pointer with clear and advance, instantiated for head and tail.
// - Operand-read mux is one function, instantiated for both sources.
// TESTING
// - Reset then alloc x3 (dest 1,2,3) -> tags 1,2,3; empty_o=0; full_o=0; commit outputs stay 0.
// - Alloc 8 without writeback -> full_o=1 after the 8th; 9th alloc ignored; tag stays 1 (wrapped).
// - Read src tag 2 while pending -> val={0,..,2}.
//   - Same cycle with execValid tag2 = 0xAB -> val=0x1_00000000000000AB.
// - Writeback tags 2,1 (0xB,0xA) on consecutive cycles:
//   - commit tag1 {1,0xA} one cycle after the tag-1 writeback;
//   - tag2 {1,0xB} the next cycle, in order.
// - Tag1 done with commitStall_i=1 for 3 cycles -> no commit; tag 1 commits the cycle after the stall drops.
// - Full ROB with head done; flush_i=1 and decodeAlloc_i=1 together:
//   - next cycle empty_o=1, decodeROBTag_o=1, no commit broadcast;
//   - async reset asserted mid-sequence clears the outputs immediately.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared constants and entry type for the reorder buffer.
package rob_pkg;

    localparam int unsigned ROB_VAL_W     = 65;
    localparam int unsigned ROB_READY_BIT = 64;
    localparam int unsigned ROB_NULL_TAG  = 0;
    localparam int unsigned REG_IDX_W     = 5;

    typedef struct packed {
        logic                 busy;
        logic                 done;
        logic [REG_IDX_W-1:0] dest_reg;
        logic [63:0]          data;
    } rob_entry_t;

endpackage

// File: rtl/rob_tag_ptr.sv
// Circular tag pointer over 1..Size; tag 0 is reserved for "register file".
module rob_tag_ptr #(
    parameter int unsigned Size = 8,
    parameter int unsigned W    = $clog2(Size + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         advance,
    output logic [W-1:0] ptr
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clear) begin
            ptr_d = W'(1);
        end else if (advance) begin
            ptr_d = (ptr_q == W'(Size)) ? W'(1) : ptr_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= W'(1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/rob_operand_source.sv
// Reorder buffer: allocates tags, forwards source operands, absorbs results and
// retires in order, broadcasting the committed tag/value to the reservation stations.
module rob_operand_source
    import rob_pkg::*;
#(
    parameter int unsigned ROBsize    = 8,
    parameter int unsigned ROBsizeLog = $clog2(ROBsize + 1),
    parameter int unsigned RegIdxW    = REG_IDX_W
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  decodeAlloc_i,
    input  logic [RegIdxW-1:0]    decodeDestReg_i,
    output logic [ROBsizeLog-1:0] decodeROBTag_o,
    output logic                  full_o,
    output logic                  empty_o,
    input  logic [ROBsizeLog-1:0] decodeSrcTag1_i,
    input  logic [ROBsizeLog-1:0] decodeSrcTag2_i,
    input  logic [63:0]           decodeRegVal1_i,
    input  logic [63:0]           decodeRegVal2_i,
    output logic [ROB_VAL_W-1:0]  decodeROBval1_o,
    output logic [ROB_VAL_W-1:0]  decodeROBval2_o,
    input  logic                  execValid_i,
    input  logic [ROBsizeLog-1:0] execTag_i,
    input  logic [63:0]           execVal_i,
    input  logic                  memValid_i,
    input  logic [ROBsizeLog-1:0] memTag_i,
    input  logic [63:0]           memVal_i,
    input  logic                  commitStall_i,
    input  logic                  flush_i,
    output logic [ROBsizeLog-1:0] issueROBTagCom_o,
    output logic [ROB_VAL_W-1:0]  issueROBvalCom_o,
    output logic [RegIdxW-1:0]    commitDestReg_o
);

    // Entry 0 is never allocated; it keeps indexing by raw tag simple.
    rob_entry_t entries_q [0:ROBsize];
    rob_entry_t entries_d [0:ROBsize];

    logic [ROBsizeLog-1:0] head;
    logic [ROBsizeLog-1:0] tail;
    logic [ROBsizeLog-1:0] count_q;
    logic [ROBsizeLog-1:0] count_d;
    logic                  alloc_en;
    logic                  commit_en;
    rob_entry_t            src1_ent;
    rob_entry_t            src2_ent;

    logic [ROBsizeLog-1:0] com_tag_q;
    logic [ROB_VAL_W-1:0]  com_val_q;
    logic [RegIdxW-1:0]    com_dest_q;

    function automatic logic tag_in_range(input logic [ROBsizeLog-1:0] tag);
        return (tag != ROBsizeLog'(ROB_NULL_TAG)) && (32'(tag) <= ROBsize);
    endfunction

    function automatic logic [ROB_VAL_W-1:0] read_operand(
        input logic [ROBsizeLog-1:0] tag,
        input logic [63:0]           reg_val,
        input rob_entry_t            ent,
        input logic                  mem_v,
        input logic [ROBsizeLog-1:0] mem_t,
        input logic [63:0]           mem_d,
        input logic                  exec_v,
        input logic [ROBsizeLog-1:0] exec_t,
        input logic [63:0]           exec_d
    );
        if (tag == ROBsizeLog'(ROB_NULL_TAG)) begin
            return {1'b1, reg_val};
        end else if (ent.busy && ent.done) begin
            return {1'b1, ent.data};
        end else if (mem_v && (mem_t == tag)) begin
            return {1'b1, mem_d};
        end else if (exec_v && (exec_t == tag)) begin
            return {1'b1, exec_d};
        end
        return {1'b0, 64'(tag)};
    endfunction

    assign full_o         = (count_q == ROBsizeLog'(ROBsize));
    assign empty_o        = (count_q == '0);
    assign decodeROBTag_o = tail;

    assign alloc_en  = decodeAlloc_i & ~full_o & ~flush_i;
    assign commit_en = ~flush_i & ~commitStall_i & entries_q[head].busy & entries_q[head].done;

    always_comb begin
        src1_ent = '0;
        src2_ent = '0;
        if (tag_in_range(decodeSrcTag1_i)) src1_ent = entries_q[decodeSrcTag1_i];
        if (tag_in_range(decodeSrcTag2_i)) src2_ent = entries_q[decodeSrcTag2_i];
        decodeROBval1_o = read_operand(decodeSrcTag1_i, decodeRegVal1_i, src1_ent,
                                       memValid_i, memTag_i, memVal_i,
                                       execValid_i, execTag_i, execVal_i);
        decodeROBval2_o = read_operand(decodeSrcTag2_i, decodeRegVal2_i, src2_ent,
                                       memValid_i, memTag_i, memVal_i,
                                       execValid_i, execTag_i, execVal_i);
    end

    // Order matters: exec, then mem (mem wins), then commit clear, then alloc; flush overrides all.
    always_comb begin
        entries_d = entries_q;
        if (execValid_i && tag_in_range(execTag_i) && entries_q[execTag_i].busy) begin
            entries_d[execTag_i].done = 1'b1;
            entries_d[execTag_i].data = execVal_i;
        end
        if (memValid_i && tag_in_range(memTag_i) && entries_q[memTag_i].busy) begin
            entries_d[memTag_i].done = 1'b1;
            entries_d[memTag_i].data = memVal_i;
        end
        if (commit_en) begin
            entries_d[head] = '0;
        end
        if (alloc_en) begin
            entries_d[tail].busy     = 1'b1;
            entries_d[tail].done     = 1'b0;
            entries_d[tail].dest_reg = decodeDestReg_i;
            entries_d[tail].data     = '0;
        end
        if (flush_i) begin
            for (int i = 0; i <= ROBsize; i++) entries_d[i] = '0;
        end
    end

    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else begin
            unique case ({alloc_en, commit_en})
                2'b10:   count_d = count_q + ROBsizeLog'(1);
                2'b01:   count_d = count_q - ROBsizeLog'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i <= ROBsize; i++) entries_q[i] <= '0;
            count_q <= '0;
        end else begin
            entries_q <= entries_d;
            count_q   <= count_d;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            com_tag_q  <= '0;
            com_val_q  <= '0;
            com_dest_q <= '0;
        end else if (commit_en) begin
            com_tag_q  <= head;
            com_val_q  <= {1'b1, entries_q[head].data};
            com_dest_q <= entries_q[head].dest_reg;
        end else begin
            com_tag_q  <= '0;
            com_val_q  <= '0;
            com_dest_q <= '0;
        end
    end

    assign issueROBTagCom_o = com_tag_q;
    assign issueROBvalCom_o = com_val_q;
    assign commitDestReg_o  = com_dest_q;

    rob_tag_ptr #(
        .Size (ROBsize),
        .W    (ROBsizeLog)
    ) u_head_ptr (
        .clk     (clk_i),
        .rst     (reset_i),
        .clear   (flush_i),
        .advance (commit_en),
        .ptr     (head)
    );

    rob_tag_ptr #(
        .Size (ROBsize),
        .W    (ROBsizeLog)
    ) u_tail_ptr (
        .clk     (clk_i),
        .rst     (reset_i),
        .clear   (flush_i),
        .advance (alloc_en),
        .ptr     (tail)
    );

endmodule

// File: tb/tb_rob_operand_source.sv
// Directed bench for rob_operand_source; commits are scored against an in-order expectation queue.
module tb_rob_operand_source;

    localparam int unsigned W  = 4;
    localparam int unsigned RW = 5;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          decodeAlloc_i;
    logic [RW-1:0] decodeDestReg_i;
    logic [W-1:0]  decodeROBTag_o;
    logic          full_o;
    logic          empty_o;
    logic [W-1:0]  decodeSrcTag1_i;
    logic [W-1:0]  decodeSrcTag2_i;
    logic [63:0]   decodeRegVal1_i;
    logic [63:0]   decodeRegVal2_i;
    logic [64:0]   decodeROBval1_o;
    logic [64:0]   decodeROBval2_o;
    logic          execValid_i;
    logic [W-1:0]  execTag_i;
    logic [63:0]   execVal_i;
    logic          memValid_i;
    logic [W-1:0]  memTag_i;
    logic [63:0]   memVal_i;
    logic          commitStall_i;
    logic          flush_i;
    logic [W-1:0]  issueROBTagCom_o;
    logic [64:0]   issueROBvalCom_o;
    logic [RW-1:0] commitDestReg_o;

    rob_operand_source dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .decodeAlloc_i    (decodeAlloc_i),
        .decodeDestReg_i  (decodeDestReg_i),
        .decodeROBTag_o   (decodeROBTag_o),
        .full_o           (full_o),
        .empty_o          (empty_o),
        .decodeSrcTag1_i  (decodeSrcTag1_i),
        .decodeSrcTag2_i  (decodeSrcTag2_i),
        .decodeRegVal1_i  (decodeRegVal1_i),
        .decodeRegVal2_i  (decodeRegVal2_i),
        .decodeROBval1_o  (decodeROBval1_o),
        .decodeROBval2_o  (decodeROBval2_o),
        .execValid_i      (execValid_i),
        .execTag_i        (execTag_i),
        .execVal_i        (execVal_i),
        .memValid_i       (memValid_i),
        .memTag_i         (memTag_i),
        .memVal_i         (memVal_i),
        .commitStall_i    (commitStall_i),
        .flush_i          (flush_i),
        .issueROBTagCom_o (issueROBTagCom_o),
        .issueROBvalCom_o (issueROBvalCom_o),
        .commitDestReg_o  (commitDestReg_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [W-1:0]  tag;
        logic [63:0]   data;
        logic [RW-1:0] dest;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;

    task automatic check(input string name, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic push_exp(input int tag, input logic [63:0] data, input int dest);
        exp_q.push_back('{tag: W'(tag), data: data, dest: RW'(dest)});
    endtask

    // Every valid commit broadcast must match the next expected retirement.
    always @(negedge clk_i) begin
        if (mon_en && !reset_i && issueROBvalCom_o[64] === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_commit", issueROBvalCom_o, 65'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("commit_tag", 65'(issueROBTagCom_o), 65'(mon_e.tag));
                check("commit_val", issueROBvalCom_o, {1'b1, mon_e.data});
                check("commit_dest", 65'(commitDestReg_o), 65'(mon_e.dest));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i = 1'b1;
        decodeAlloc_i = 0; decodeDestReg_i = '0;
        decodeSrcTag1_i = '0; decodeSrcTag2_i = '0;
        decodeRegVal1_i = '0; decodeRegVal2_i = '0;
        execValid_i = 0; execTag_i = '0; execVal_i = '0;
        memValid_i = 0; memTag_i = '0; memVal_i = '0;
        commitStall_i = 0; flush_i = 0;
        repeat (2) @(negedge clk_i);

        check("rst_full", 65'(full_o), 65'd0);
        check("rst_empty", 65'(empty_o), 65'd1);
        check("rst_tag", 65'(decodeROBTag_o), 65'd1);
        check("rst_com_tag", 65'(issueROBTagCom_o), 65'd0);
        check("rst_com_val", issueROBvalCom_o, 65'd0);
        check("rst_com_dest", 65'(commitDestReg_o), 65'd0);
        reset_i = 1'b0;
        mon_en  = 1'b1;
        @(negedge clk_i);

        // Allocate tags 1..3
        for (int i = 1; i <= 3; i++) begin
            decodeAlloc_i = 1; decodeDestReg_i = RW'(i);
            #1 check("alloc_tag", 65'(decodeROBTag_o), 65'(i));
            @(negedge clk_i);
        end
        decodeAlloc_i = 0;
        check("alloc3_empty", 65'(empty_o), 65'd0);
        check("alloc3_full", 65'(full_o), 65'd0);
        check("alloc3_next_tag", 65'(decodeROBTag_o), 65'd4);
        check("alloc3_no_commit", issueROBvalCom_o, 65'd0);

        // Fill to 8, then an ignored 9th alloc
        for (int i = 4; i <= 8; i++) begin
            decodeAlloc_i = 1; decodeDestReg_i = RW'(i);
            #1 check("alloc_tag", 65'(decodeROBTag_o), 65'(i));
            @(negedge clk_i);
        end
        decodeAlloc_i = 0;
        check("fill_full", 65'(full_o), 65'd1);
        check("fill_tag_wrap", 65'(decodeROBTag_o), 65'd1);
        decodeAlloc_i = 1; decodeDestReg_i = 5'd31;
        @(negedge clk_i);
        decodeAlloc_i = 0;
        check("ninth_full", 65'(full_o), 65'd1);
        check("ninth_tag", 65'(decodeROBTag_o), 65'd1);
        check("ninth_empty", 65'(empty_o), 65'd0);

        // Operand reads within one low phase (no edge in between)
        decodeSrcTag1_i = 4'd2; decodeSrcTag2_i = 4'd0; decodeRegVal2_i = 64'h1234;
        #1 check("src1_pending", decodeROBval1_o, {1'b0, 64'd2});
        check("src2_regfile", decodeROBval2_o, {1'b1, 64'h1234});
        execValid_i = 1; execTag_i = 4'd2; execVal_i = 64'hAB;
        #1 check("src1_exec_bypass", decodeROBval1_o, 65'h1_0000_0000_0000_00AB);
        memValid_i = 1; memTag_i = 4'd2; memVal_i = 64'hCD;
        decodeSrcTag2_i = 4'd5;
        #1 check("src1_mem_over_exec", decodeROBval1_o, {1'b1, 64'hCD});
        check("src2_pending_other", decodeROBval2_o, {1'b0, 64'd5});
        execValid_i = 0; memValid_i = 0; decodeSrcTag2_i = 4'd0;
        @(negedge clk_i);

        // Out-of-order writeback, in-order retirement
        execValid_i = 1; execTag_i = 4'd2; execVal_i = 64'hB;
        @(negedge clk_i);
        execTag_i = 4'd1; execVal_i = 64'hA;
        push_exp(1, 64'hA, 1);
        push_exp(2, 64'hB, 2);
        @(negedge clk_i);
        execValid_i = 0;
        check("commit_latency", 65'(issueROBvalCom_o[64]), 65'd0);
        #1 check("src1_done_entry", decodeROBval1_o, {1'b1, 64'hB});
        @(negedge clk_i);
        check("commit_first_tag", 65'(issueROBTagCom_o), 65'd1);
        @(negedge clk_i);
        check("commit_second_tag", 65'(issueROBTagCom_o), 65'd2);
        check("after_two_full", 65'(full_o), 65'd0);
        decodeSrcTag1_i = 4'd0;

        // Commit stall for three edges
        commitStall_i = 1; execValid_i = 1; execTag_i = 4'd3; execVal_i = 64'h33;
        @(negedge clk_i);
        execValid_i = 0;
        for (int i = 0; i < 3; i++) begin
            check("stall_no_commit", issueROBvalCom_o, 65'd0);
            if (i < 2) @(negedge clk_i);
        end
        commitStall_i = 0;
        push_exp(3, 64'h33, 3);
        @(negedge clk_i);
        check("stall_release_tag", 65'(issueROBTagCom_o), 65'd3);

        // Refill; a commit while full must not let alloc through in the same cycle
        for (int i = 1; i <= 3; i++) begin
            decodeAlloc_i = 1; decodeDestReg_i = RW'(i);
            @(negedge clk_i);
        end
        decodeAlloc_i = 0;
        check("refill_full", 65'(full_o), 65'd1);
        check("refill_tag", 65'(decodeROBTag_o), 65'd4);
        commitStall_i = 1; execValid_i = 1; execTag_i = 4'd4; execVal_i = 64'h44;
        @(negedge clk_i);
        execValid_i = 0; commitStall_i = 0;
        decodeAlloc_i = 1; decodeDestReg_i = 5'd9;
        push_exp(4, 64'h44, 4);
        @(negedge clk_i);
        decodeAlloc_i = 0;
        check("full_commit_no_alloc_full", 65'(full_o), 65'd0);
        check("full_commit_no_alloc_tag", 65'(decodeROBTag_o), 65'd4);
        decodeAlloc_i = 1; decodeDestReg_i = 5'd9;
        @(negedge clk_i);
        decodeAlloc_i = 0;
        check("refull_tag", 65'(decodeROBTag_o), 65'd5);

        // Flush with done head and a concurrent alloc
        commitStall_i = 1; execValid_i = 1; execTag_i = 4'd5; execVal_i = 64'h55;
        @(negedge clk_i);
        execValid_i = 0; commitStall_i = 0;
        flush_i = 1; decodeAlloc_i = 1; decodeDestReg_i = 5'd10;
        @(negedge clk_i);
        flush_i = 0; decodeAlloc_i = 0;
        check("flush_empty", 65'(empty_o), 65'd1);
        check("flush_full", 65'(full_o), 65'd0);
        check("flush_tag", 65'(decodeROBTag_o), 65'd1);
        check("flush_no_commit", issueROBvalCom_o, 65'd0);
        @(negedge clk_i);
        check("flush_no_late_commit", issueROBvalCom_o, 65'd0);

        // Same-tag exec+mem writeback, then async reset while a commit is on the outputs
        decodeAlloc_i = 1; decodeDestReg_i = 5'd7;
        @(negedge clk_i);
        decodeDestReg_i = 5'd8;
        execValid_i = 1; execTag_i = 4'd1; execVal_i = 64'h11;
        memValid_i = 1; memTag_i = 4'd1; memVal_i = 64'h22;
        push_exp(1, 64'h22, 7);
        @(negedge clk_i);
        decodeAlloc_i = 0; execValid_i = 0; memValid_i = 0;
        @(negedge clk_i);
        check("pre_reset_com_tag", 65'(issueROBTagCom_o), 65'd1);
        #1 reset_i = 1;
        #1 check("async_rst_com_tag", 65'(issueROBTagCom_o), 65'd0);
        check("async_rst_com_val", issueROBvalCom_o, 65'd0);
        check("async_rst_com_dest", 65'(commitDestReg_o), 65'd0);
        check("async_rst_empty", 65'(empty_o), 65'd1);
        check("async_rst_tag", 65'(decodeROBTag_o), 65'd1);
        @(negedge clk_i);
        reset_i = 0;
        @(negedge clk_i);
        check("post_rst_empty", 65'(empty_o), 65'd1);
        check("post_rst_no_commit", issueROBvalCom_o, 65'd0);

        check("scoreboard_drained", 65'(exp_q.size()), 65'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
